// File: rtl/rect_loader_pkg.sv
// rect_pkg: descriptor layout, FSM states and an index-width helper shared by rect_loader.
package rect_pkg;

    localparam int WORDS_PER_RECT = 5;

    localparam logic [2:0] W_X     = 3'd0;
    localparam logic [2:0] W_Y     = 3'd1;
    localparam logic [2:0] W_W     = 3'd2;
    localparam logic [2:0] W_H     = 3'd3;
    localparam logic [2:0] W_COLOR = 3'(WORDS_PER_RECT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    // A single-entry bank still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rect_loader_if.sv
// rect_loader_if: video-memory read port plus rectangle-bank write port of rect_loader.
interface rect_loader_if #(
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int IDX_WIDTH   = 6
);
    logic                   mem_rd;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [COORD_WIDTH-1:0] mem_data;
    logic                   wr_en;
    logic [IDX_WIDTH-1:0]   wr_index;
    logic [COORD_WIDTH-1:0] rect_left;
    logic [COORD_WIDTH-1:0] rect_top;
    logic [COORD_WIDTH-1:0] rect_right;
    logic [COORD_WIDTH-1:0] rect_bottom;
    logic [COLOR_WIDTH-1:0] rect_color;

    modport master (
        output mem_rd, mem_addr, wr_en, wr_index,
               rect_left, rect_top, rect_right, rect_bottom, rect_color,
        input  mem_data
    );

    modport slave (
        input  mem_rd, mem_addr, wr_en, wr_index,
               rect_left, rect_top, rect_right, rect_bottom, rect_color,
        output mem_data
    );

endinterface

// File: rtl/rect_loader_bounds_add.sv
// rect_bounds_add: far edge = origin + extent; RECT_LOADER_SATURATE_EN clamps a carry to all-ones.
module rect_bounds_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);

`ifdef RECT_LOADER_SATURATE_EN
    logic [W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};
    assign s   = sum[W] ? '1 : sum[W-1:0];
`else
    assign s = a + b;
`endif

endmodule

// File: rtl/rect_loader.sv
// rect_loader: on start, reads RECT_COUNT 5-word descriptors and writes bounds+color into the bank.
// Overflow of right/bottom saturates when RECT_LOADER_SATURATE_EN is defined, otherwise wraps.
module rect_loader
    import rect_pkg::*;
#(
    parameter int                    RECT_COUNT  = 64,
    parameter int                    COORD_WIDTH = 16,
    parameter int                    COLOR_WIDTH = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    rect_loader_if.master bus
);

    localparam int             IW   = idx_width(RECT_COUNT);
    localparam logic [IW-1:0]  LAST = IW'(RECT_COUNT - 1);

    state_t                 state;
    logic [2:0]             wcnt;
    logic [IW-1:0]          rcnt;
    logic                   dv;
    logic [2:0]             dw;
    logic [IW-1:0]          dr;
    logic [COORD_WIDTH-1:0] x, y, w, h;
    logic [COORD_WIDTH-1:0] sx, sy;

    rect_bounds_add #(.W(COORD_WIDTH)) u_add_x (.a(x), .b(w), .s(sx));
    rect_bounds_add #(.W(COORD_WIDTH)) u_add_y (.a(y), .b(h), .s(sy));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            wcnt            <= '0;
            rcnt            <= '0;
            dv              <= 1'b0;
            dw              <= '0;
            dr              <= '0;
            x               <= '0;
            y               <= '0;
            w               <= '0;
            h               <= '0;
            bus.mem_rd      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_index    <= '0;
            bus.rect_left   <= '0;
            bus.rect_top    <= '0;
            bus.rect_right  <= '0;
            bus.rect_bottom <= '0;
            bus.rect_color  <= '0;
        end else begin
            // Tag each read so the returning word lands in the right field next cycle.
            dv        <= bus.mem_rd;
            dw        <= wcnt;
            dr        <= rcnt;
            done      <= 1'b0;
            bus.wr_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state        <= FETCH;
                    busy         <= 1'b1;
                    bus.mem_rd   <= 1'b1;
                    bus.mem_addr <= BASE_ADDR;
                    wcnt         <= '0;
                    rcnt         <= '0;
                end
                FETCH: begin
                    bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(1);
                    if (wcnt == W_COLOR) begin
                        wcnt <= '0;
                        rcnt <= rcnt + IW'(1);
                        if (rcnt == LAST) begin
                            state      <= DRAIN;
                            bus.mem_rd <= 1'b0;
                        end
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                DRAIN: if (bus.wr_en && bus.wr_index == LAST) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: state <= IDLE;
            endcase
            if (dv) begin
                case (dw)
                    W_X: x <= bus.mem_data;
                    W_Y: y <= bus.mem_data;
                    W_W: w <= bus.mem_data;
                    W_H: h <= bus.mem_data;
                    W_COLOR: begin
                        bus.wr_en       <= 1'b1;
                        bus.wr_index    <= dr;
                        bus.rect_left   <= x;
                        bus.rect_top    <= y;
                        bus.rect_right  <= sx;
                        bus.rect_bottom <= sy;
                        bus.rect_color  <= bus.mem_data[COLOR_WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rect_loader.sv
// tb_rect_loader: directed checks of rect_loader (4-rect and 1-rect builds) against hand-computed tables.
module tb_rect_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic busy0, done0, busy1, done1;
    int   n_run = 0;
    int   n_fail = 0;

    logic [15:0] mem [256];
    logic [15:0] ex_l [5] = '{16'd10, 16'hFFF0, 16'd100, 16'hFFFF, 16'd1};
    logic [15:0] ex_t [5] = '{16'd20, 16'd5, 16'd200, 16'hFFFF, 16'd2};
`ifdef RECT_LOADER_SATURATE_EN
    logic [15:0] ex_r [5] = '{16'd40, 16'hFFFF, 16'd100, 16'hFFFF, 16'd4};
    logic [15:0] ex_b [5] = '{16'd60, 16'd5, 16'd207, 16'hFFFF, 16'd6};
`else
    logic [15:0] ex_r [5] = '{16'd40, 16'h0010, 16'd100, 16'h0000, 16'd4};
    logic [15:0] ex_b [5] = '{16'd60, 16'd5, 16'd207, 16'h0000, 16'd6};
`endif
    logic [15:0] ex_c [5] = '{16'hF800, 16'h07E0, 16'h001F, 16'h1234, 16'hABCD};

    rect_loader_if #(.IDX_WIDTH(2)) a ();
    rect_loader_if #(.IDX_WIDTH(1)) b ();

    rect_loader #(.RECT_COUNT(4), .BASE_ADDR(16'h0100)) dut (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .bus(a.master)
    );

    rect_loader #(.RECT_COUNT(1), .BASE_ADDR(16'h0040)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(b.master)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        a.mem_data <= mem[a.mem_addr[7:0]];
        b.mem_data <= mem[b.mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for a load that saw start in relative cycle 0 (rel < 0 means idle).
    task automatic chk_cyc(input int rel, input int n, input logic [15:0] base, input int rb,
                           input logic rd, input logic [15:0] addr, input logic bsy, input logic dn,
                           input logic wr, input int idx, input logic [15:0] l, input logic [15:0] t,
                           input logic [15:0] r, input logic [15:0] bt, input logic [15:0] c);
        bit erd = rel >= 1 && rel <= 5 * n;
        bit ewr = rel >= 7 && (rel - 7) % 5 == 0 && (rel - 7) / 5 < n;
        int ei  = ewr ? (rel - 7) / 5 : 0;
        chk("mem_rd", 32'(rd), 32'(erd));
        if (erd) chk("mem_addr", 32'(addr), 32'(base + 16'(rel - 1)));
        chk("busy", 32'(bsy), 32'(rel >= 1 && rel <= 5 * n + 2));
        chk("done", 32'(dn), 32'(rel == 5 * n + 3));
        chk("wr_en", 32'(wr), 32'(ewr));
        if (ewr || rel == 8) begin
            chk("wr_index", 32'(idx), 32'(ei));
            chk("left", 32'(l), 32'(ex_l[rb + ei]));
            chk("top", 32'(t), 32'(ex_t[rb + ei]));
            chk("right", 32'(r), 32'(ex_r[rb + ei]));
            chk("bottom", 32'(bt), 32'(ex_b[rb + ei]));
            chk("color", 32'(c), 32'(ex_c[rb + ei]));
        end
    endtask

    task automatic cyc0(input int rel);
        chk_cyc(rel, 4, 16'h0100, 0, a.mem_rd, a.mem_addr, busy0, done0, a.wr_en, int'(a.wr_index),
                a.rect_left, a.rect_top, a.rect_right, a.rect_bottom, a.rect_color);
    endtask

    task automatic cyc1(input int rel);
        chk_cyc(rel, 1, 16'h0040, 4, b.mem_rd, b.mem_addr, busy1, done1, b.wr_en, int'(b.wr_index),
                b.rect_left, b.rect_top, b.rect_right, b.rect_bottom, b.rect_color);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {28'd0, a.mem_rd, a.wr_en, busy0, done0}, 32'd0);
        chk({tag, "_addr"}, 32'(a.mem_addr), 32'd0);
        chk({tag, "_idx"}, 32'(a.wr_index), 32'd0);
        chk({tag, "_lt"}, {a.rect_left, a.rect_top}, 32'd0);
        chk({tag, "_rb"}, {a.rect_right, a.rect_bottom}, 32'd0);
        chk({tag, "_c"}, 32'(a.rect_color), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h5A5A;
        {mem[0], mem[1], mem[2], mem[3], mem[4]}       = {16'd10, 16'd20, 16'd30, 16'd40, 16'hF800};
        {mem[5], mem[6], mem[7], mem[8], mem[9]}       = {16'hFFF0, 16'd5, 16'h0020, 16'd0, 16'h07E0};
        {mem[10], mem[11], mem[12], mem[13], mem[14]}  = {16'd100, 16'd200, 16'd0, 16'd7, 16'h001F};
        {mem[15], mem[16], mem[17], mem[18], mem[19]}  = {16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 16'h1234};
        {mem[64], mem[65], mem[66], mem[67], mem[68]}  = {16'd1, 16'd2, 16'd3, 16'd4, 16'hABCD};
        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk("reset_b", {30'd0, b.mem_rd, b.wr_en}, 32'd0);
        reset = 1'b0;
        // Full load with ignored re-starts while busy (3) and in DONE (23), then a fresh load at 30.
        for (int t = 0; t <= 57; t++) begin
            @(negedge clk);
            cyc0(t < 30 ? t : t - 30);
            start0 = (t == 0 || t == 3 || t == 23 || t == 30);
        end
        start0 = 1'b0;
        // Reset mid-load, then reload from rect 0.
        for (int t = 0; t <= 42; t++) begin
            @(negedge clk);
            cyc0(t < 10 ? t : (t < 15 ? -1 : t - 15));
            if (t == 9) begin
                reset = 1'b1;
                #1 chk_zero("midreset");
            end
            if (t == 10) reset = 1'b0;
            start0 = (t == 0 || t == 15);
        end
        start0 = 1'b0;
        // Single-rect build.
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            cyc1(t);
            start1 = (t == 0);
        end
        start1 = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_loader.md
Name: rect_loader

Overview:
Upstream of the per-pixel rectangle hit comparators. On each frame-start pulse (vblank), walks a rectangle table in video memory and turns each 5-word descriptor (x, y, width, height, color) into absolute bounds (left, top, right, bottom) plus color. Writes one entry per rectangle into the rectangle register bank that drives the comparators.

Parameters:
RECT_COUNT, 64, number of table entries loaded per frame (>=1)
COORD_WIDTH, 16, coordinate/word width
COLOR_WIDTH, 16, color field width (<= COORD_WIDTH, taken from low bits)
ADDR_WIDTH, 16, memory address width
BASE_ADDR, 16'h0000, word address of rect 0 word 0

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle load request (vblank)
mem_rd  out  1  read strobe; data returned next cycle
mem_addr  out  ADDR_WIDTH  read address
mem_data  in  COORD_WIDTH  read data, valid the cycle after mem_rd
busy  out  1  load in progress
done  out  1  one-cycle pulse after last write
wr_en  out  1  bank write strobe
wr_index  out  clog2(RECT_COUNT)  bank entry index
rect_left, rect_top, rect_right, rect_bottom  out  COORD_WIDTH each  bounds written
rect_color  out  COLOR_WIDTH  color written

Behaviour:
- Reset: all outputs 0, state IDLE, rect and word counters 0.
- States: IDLE -> FETCH on start; FETCH -> DRAIN after the last read issues; DRAIN -> DONE after the last wr_en; DONE -> IDLE after 1 cycle.
- IDLE: start sampled high at cycle 0.
- FETCH: reads issue back-to-back with no bubbles.
  - Rect i word k: mem_rd=1 and mem_addr=BASE_ADDR+5*i+k in cycle 1+5i+k.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Capture: mem_data registered in the cycle it is valid.
  - left=x, top=y.
  - right = x+width, bottom = y+height, each from a COORD_WIDTH+1 bit sum.
  - Overflow handling per the optional feature.
- wr_en for rect i: a one-cycle pulse in cycle 7+5i, with wr_index=i and all rect_* fields stable in that cycle.
  - wr_index and rect_* hold their values between pulses.
- busy: high in cycles 1 .. 5*RECT_COUNT+2.
- done: pulses in cycle 5*RECT_COUNT+3, the same cycle busy falls.
- start while busy or in DONE: ignored; no restart, no queueing.
- width=0 or height=0: entry still written with right=left or bottom=top. The comparator's strict "<" makes it never hit.
- Reset mid-load: immediate return to IDLE with all outputs 0. Partial bank contents are left as written; no further wr_en.
- mem_rd is never high outside FETCH.

Optional Feature:
RECT_LOADER_SATURATE_EN
- Defined: a sum carry clamps right/bottom to all-ones (16'hFFFF), so rects extending off-screen cover to the edge.
- Undefined: right/bottom are the low COORD_WIDTH bits of the sum (wrap). A wrapped rect may become empty; that is accepted.

Decomposition:
- Package rect_pkg:
  - WORDS_PER_RECT=5
  - word offsets W_X=0, W_Y=1, W_W=2, W_H=3, W_COLOR=4
  - FSM state enum IDLE/FETCH/DRAIN/DONE
- Sub-module rect_bounds_add (combinational x+width with optional saturation, instantiated twice). It is small but keeps the macro logic in one place.
- Counters and FSM stay in rect_loader.

Test Plan:
- RECT_COUNT=4, BASE_ADDR=16'h0100, memory model with 1-cycle latency: pulse start at cycle 0.
  -> mem_addr 0x100..0x113 in cycles 1..20
  -> wr_en in cycles 7, 12, 17, 22 with wr_index 0..3
  -> done in cycle 23; busy cycles 1..22.
- Rect 0 = (10, 20, 30, 40, 16'hF800) -> left=10 top=20 right=40 bottom=60 color=16'hF800.
- Rect 1 = (16'hFFF0, 5, 16'h0020, 0):
  - macro on -> right=16'hFFFF, bottom=5
  - macro off -> right=16'h0010, bottom=5.
- start re-pulsed at cycles 3 and 23 -> no extra reads; sequence identical to the first scenario; next start at cycle 30 begins a fresh load at cycle 31.
- reset asserted at cycle 9 -> all outputs 0 immediately; no wr_en after cycle 7; start at cycle 15 reloads from rect 0.
- RECT_COUNT=1 -> reads cycles 1..5, wr_en cycle 7, done cycle 8.
